rsa_encoder: RTL and testbench

RSA_ENCODER -- requirements
Module: rsa_encoder

---
 rtl/rsa_pkg.sv | 18 +
 rtl/montgomery_mul.sv | 73 +++++++
 rtl/rsa_encoder.sv | 117 +++++++++++
 tb/tb_rsa_encoder.sv | 123 ++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// rsa_pkg: shared FSM state encoding and Montgomery step-count helper for rsa_encoder.
package rsa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TO_MONT,
        EXP_SQR,
        EXP_MUL,
        FROM_MONT,
        DONE
    } state_t;

    // Number of digit steps one Montgomery multiply takes: ceil(n_bit/logr).
    function automatic int MM_STEPS(input int n_bit, input int logr);
        return (n_bit + logr - 1) / logr;
    endfunction

endpackage

// File: rtl/montgomery_mul.sv
// montgomery_mul: radix-2^logr Montgomery multiplier, result = a*b*2^-n_bit mod n.
// Ports: clk, rst_n (async active-low), start (load a/b and begin), a, b (operands < n),
//        result (valid with done), done (one-cycle pulse, ceil(n_bit/logr)+1 cycles after start).
module montgomery_mul import rsa_pkg::*; #(
    parameter int n     = 79,
    parameter int n_bit = 7,
    parameter int logr  = 3,
    parameter int p     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [n_bit-1:0] a,
    input  logic [n_bit-1:0] b,
    output logic [n_bit-1:0] result,
    output logic             done
);

    localparam int W     = n_bit + logr + 2;
    localparam int STEPS = MM_STEPS(n_bit, logr);
    localparam int CW    = $clog2(STEPS + 1);

    logic [W-1:0]     t, t1, t2, q, mask, digit;
    logic [n_bit-1:0] a_sh, b_r;
    logic [CW-1:0]    cnt;
    logic             busy;
    int               rem, w;

    // The last step may consume fewer than logr bits; q is reduced to the same width
    // so the shift always clears exactly the zeroed low bits.
    always_comb begin
        rem   = n_bit - int'(cnt) * logr;
        w     = (rem < logr) ? ((rem > 0) ? rem : 0) : logr;
        mask  = (W'(1) << w) - W'(1);
        digit = W'(a_sh) & mask;
        t1    = t + digit * W'(b_r);
        q     = (t1 * W'(p)) & mask;
        t2    = (t1 + q * W'(n)) >> w;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t      <= '0;
            a_sh   <= '0;
            b_r    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                a_sh <= a;
                b_r  <= b;
                t    <= '0;
                cnt  <= '0;
                busy <= 1'b1;
            end else if (busy) begin
                if (cnt == CW'(STEPS)) begin
                    // T < 2n here, so one conditional subtract finishes the reduction.
                    result <= (t >= W'(n)) ? n_bit'(t - W'(n)) : n_bit'(t);
                    done   <= 1'b1;
                    busy   <= 1'b0;
                end else begin
                    t    <= t2;
                    a_sh <= a_sh >> logr;
                    cnt  <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/rsa_encoder.sv
// rsa_encoder: RSA encryption data_out = data_in^e mod n via left-to-right Montgomery exponentiation.
// Ports: clk, rst_n (async active-low), start (level request, sampled in IDLE/DONE),
//        data_in (plaintext), data_out (ciphertext, held until next result), done (result valid).
// Option: define RSA_INPUT_REDUCE_EN to reduce a latched plaintext m >= n to m-n.
module rsa_encoder import rsa_pkg::*; #(
    parameter int n      = 79,
    parameter int n_bit  = 7,
    parameter int logr   = 3,
    parameter int p      = 1,
    parameter int Rmodn  = 49,
    parameter int R2modn = 31,
    parameter int e      = 5,
    parameter int e_bit  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [n_bit-1:0] data_in,
    output logic [n_bit-1:0] data_out,
    output logic             done
);

    localparam int               IW = (e_bit > 1) ? $clog2(e_bit) : 1;
    localparam logic [e_bit-1:0] E  = e_bit'(e);
    localparam logic [n_bit-1:0] NN = n_bit'(n);
    localparam logic [n_bit-1:0] RM = n_bit'(Rmodn);
    localparam logic [n_bit-1:0] R2 = n_bit'(R2modn);

    state_t           state, bit_next;
    logic [n_bit-1:0] x_r, acc, mm_a, mm_b, mm_res, m_in, op_a, op_b;
    logic [IW-1:0]    idx;
    logic             issued, mm_start, mm_done, mm_state, fin;

`ifdef RSA_INPUT_REDUCE_EN
    // data_in < 2^n_bit < 2n, so a single subtraction fully reduces it.
    assign m_in = (data_in >= NN) ? data_in - NN : data_in;
`else
    assign m_in = data_in;
`endif

    assign mm_state = state == TO_MONT || state == EXP_SQR || state == EXP_MUL || state == FROM_MONT;
    assign fin      = issued && mm_done;
    assign bit_next = (idx == '0) ? FROM_MONT : EXP_SQR;

    always_comb begin
        op_a = (state == TO_MONT) ? x_r : acc;
        op_b = (state == TO_MONT) ? R2 : (state == EXP_SQR) ? acc : (state == EXP_MUL) ? x_r : n_bit'(1);
    end

    montgomery_mul #(.n(n), .n_bit(n_bit), .logr(logr), .p(p)) u_mm (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mm_start),
        .a      (mm_a),
        .b      (mm_b),
        .result (mm_res),
        .done   (mm_done)
    );

    // Each multiplying state first issues one MM (issued=0), then waits for its done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            x_r      <= '0;
            acc      <= '0;
            idx      <= '0;
            mm_a     <= '0;
            mm_b     <= '0;
            mm_start <= 1'b0;
            issued   <= 1'b0;
            data_out <= '0;
            done     <= 1'b0;
        end else begin
            mm_start <= 1'b0;
            if (mm_state && !issued) begin
                mm_a     <= op_a;
                mm_b     <= op_b;
                mm_start <= 1'b1;
                issued   <= 1'b1;
            end
            if (fin) issued <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    x_r   <= m_in;
                    state <= TO_MONT;
                end
                TO_MONT: if (fin) begin
                    x_r   <= mm_res;
                    acc   <= RM;
                    idx   <= IW'(e_bit - 1);
                    state <= EXP_SQR;
                end
                EXP_SQR: if (fin) begin
                    acc   <= mm_res;
                    state <= E[idx] ? EXP_MUL : bit_next;
                    if (!E[idx]) idx <= idx - IW'(1);
                end
                EXP_MUL: if (fin) begin
                    acc   <= mm_res;
                    state <= bit_next;
                    idx   <= idx - IW'(1);
                end
                FROM_MONT: if (fin) begin
                    data_out <= mm_res;
                    done     <= 1'b1;
                    state    <= DONE;
                end
                DONE: if (!start) begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_encoder.sv
// tb_rsa_encoder: directed self-checking bench for rsa_encoder against a modular-exponent model.
module tb_rsa_encoder;

    localparam int N = 79;
    localparam int E = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [6:0] data_in = '0;
    logic [6:0] data_out;
    logic       done;

    int         vectors = 0;
    int         miscompares = 0;
    int         first_lat = -1;
    logic [6:0] exp_data = '0;

    rsa_encoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .data_in  (data_in),
        .data_out (data_out),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] model(input int m);
        longint r = 1;
        for (int i = 0; i < E; i++) r = (r * (m % N)) % N;
        return 7'(r);
    endfunction

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Whenever a result is presented it must equal the model's value for the latched plaintext.
    always @(negedge clk) begin
        if (rst_n && done) begin
            vectors++;
            if (data_out !== exp_data) begin
                miscompares++;
                $display("FAIL cmp: data_out %0d, expected %0d", data_out, exp_data);
            end
        end
    end

    task automatic run(input logic [6:0] m, input int hold, input int lit);
        int  lat = 0;
        logic got = 1'b0;
        exp_data = model(m);
        data_in  = m;
        start    = 1'b1;
        @(posedge clk);
        #1 data_in = ~m;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            lat++;
            got = done;
        end
        if (!got) begin
            chk("timeout", 0, 1);
        end else begin
            chk($sformatf("result(%0d)", m), data_out, lit);
            if (first_lat < 0) first_lat = lat;
            else chk("latency", lat, first_lat);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("done_hold", done, 1);
        end
        start = 1'b0;
        @(negedge clk);
        chk("done_drop", done, 0);
        chk("out_keep", data_out, lit);
    endtask

    initial begin
        chk("model20", model(20), 26);
        chk("model57", model(57), 12);
        chk("model78", model(78), 78);
        repeat (3) @(negedge clk);
        chk("rst_done", done, 0);
        chk("rst_out", data_out, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run(7'd20, 5, 26);
        run(7'd57, 50, 12);
        run(7'd0, 2, 0);
        run(7'd1, 2, 1);
        run(7'd78, 2, 78);
        run(7'd2, 2, 32);
        run(7'd3, 2, 6);
        // Abort mid-exponentiation, then confirm a clean restart.
        data_in = 7'd57;
        start   = 1'b1;
        @(posedge clk);
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        chk("abort_done", done, 0);
        chk("abort_out", data_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_idle", done, 0);
        run(7'd57, 2, 12);
`ifdef RSA_INPUT_REDUCE_EN
        run(7'd99, 2, 26);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
